// File: rtl/spandex_types_pkg.sv
// Shared Spandex LLC request types and arbiter constants used by the
// request-ingress stage and its per-port FIFOs.
package spandex_types;

    localparam int MIX_MSG_W     = 5;
    localparam int HPROT_W       = 2;
    localparam int LINE_ADDR_W   = 28;
    localparam int LINE_W        = 128;
    localparam int CACHE_ID_W    = 5;
    localparam int WORD_OFFSET_W = 2;
    localparam int WORDS_PER_LINE = 4;

    typedef logic [MIX_MSG_W-1:0]      mix_msg_t;
    typedef logic [HPROT_W-1:0]        hprot_t;
    typedef logic [LINE_ADDR_W-1:0]    line_addr_t;
    typedef logic [LINE_W-1:0]         line_t;
    typedef logic [CACHE_ID_W-1:0]     cache_id_t;
    typedef logic [WORD_OFFSET_W-1:0]  word_offset_t;
    typedef logic [WORDS_PER_LINE-1:0] word_mask_t;

    typedef struct packed {
        mix_msg_t     coh_msg;
        hprot_t       hprot;
        line_addr_t   addr;
        line_t        line;
        cache_id_t    req_id;
        word_offset_t word_offset;
        word_offset_t valid_words;
        word_mask_t   word_mask;
    } llc_req_pkt_t;

    localparam int LLC_ARB_RR    = 0;
    localparam int LLC_ARB_FIXED = 1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/llc_req_in_arb_fifo.sv
// Per-port request FIFO: register array, wrapping read/write pointers and
// an entry count that also drives the full/empty flags.
module llc_req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/llc_req_in_arb.sv
// N-port ingress stage for the LLC request channel: per-port FIFOs merged by a
// round-robin or fixed-priority arbiter with a grant lock and a stall counter.
//
// state      | meaning
// ARB_IDLE   | grant follows the combinational pick over non-empty FIFOs
// ARB_LOCKED | output stalled; grant frozen until the handshake completes
module llc_req_in_arb
    import spandex_types::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  FIFO_DEPTH = 4,
    parameter int  ARB_MODE   = LLC_ARB_RR,
    localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic         [NUM_PORTS-1:0]   in_valid,
    output logic         [NUM_PORTS-1:0]   in_ready,
    input  llc_req_pkt_t [NUM_PORTS-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output llc_req_pkt_t                   out_data,
    output logic         [PW-1:0]          out_port,
    output logic [NUM_PORTS-1:0][CW-1:0]   occupancy,
    output logic         [15:0]            stall_cnt
);

    llc_req_pkt_t         head [NUM_PORTS];
    logic [NUM_PORTS-1:0] full, empty, pop;

    arb_state_t  state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic [PW-1:0] pick, sel, base;
    logic          handshake;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        llc_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (llc_req_pkt_t)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (in_valid[i] & in_ready[i]),
            .push_data (in_data[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (occupancy[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
        // Ready depends only on the registered count, never on out_ready.
        assign in_ready[i] = rst & ~full[i];
        assign pop[i]      = handshake & (sel == PW'(i));
    end

    // First requester at or after base, wrapping; base 0 gives fixed priority.
    function automatic logic [PW-1:0] arb_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [PW-1:0] start);
        int            idx;
        logic [PW-1:0] win;
        win = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (|(req & (NUM_PORTS'(1) << idx))) win = PW'(idx);
        end
        return win;
    endfunction

    assign base      = (ARB_MODE == LLC_ARB_FIXED) ? '0 : rr_ptr_q;
    assign pick      = arb_pick(~empty, base);
    assign sel       = (state_q == ARB_LOCKED) ? grant_q : pick;
    assign out_valid = (state_q == ARB_LOCKED) | (|(~empty));
    assign handshake = out_valid & out_ready;
    assign out_data  = head[sel];
    assign out_port  = sel;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (out_valid && !out_ready) begin
                    state_d = ARB_LOCKED;
                    grant_d = sel;
                end
            end
            ARB_LOCKED: begin
                if (out_ready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        if (handshake && ARB_MODE == LLC_ARB_RR) begin
            rr_ptr_d = (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
        end
        if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_llc_req_in_arb.sv
// Directed bench: a round-robin and a fixed-priority 3-port instance, each
// checked against a queue of expected (port, packet) results.
module tb_llc_req_in_arb;
    import spandex_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         [2:0]      in_valid_rr, in_ready_rr, in_valid_fp, in_ready_fp;
    llc_req_pkt_t [2:0]      in_data_rr, in_data_fp;
    logic                    out_valid_rr, out_ready_rr, out_valid_fp, out_ready_fp;
    llc_req_pkt_t            out_data_rr, out_data_fp;
    logic         [1:0]      out_port_rr, out_port_fp;
    logic         [2:0][2:0] occ_rr, occ_fp;
    logic         [15:0]     stall_rr, stall_fp;

    llc_req_in_arb #(.NUM_PORTS(3), .FIFO_DEPTH(4), .ARB_MODE(LLC_ARB_RR)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid_rr), .in_ready(in_ready_rr),
        .in_data(in_data_rr), .out_valid(out_valid_rr), .out_ready(out_ready_rr),
        .out_data(out_data_rr), .out_port(out_port_rr), .occupancy(occ_rr),
        .stall_cnt(stall_rr)
    );

    llc_req_in_arb #(.NUM_PORTS(3), .FIFO_DEPTH(4), .ARB_MODE(LLC_ARB_FIXED)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid_fp), .in_ready(in_ready_fp),
        .in_data(in_data_fp), .out_valid(out_valid_fp), .out_ready(out_ready_fp),
        .out_data(out_data_fp), .out_port(out_port_fp), .occupancy(occ_fp),
        .stall_cnt(stall_fp)
    );

    typedef struct packed {
        logic [1:0]   port;
        llc_req_pkt_t pkt;
    } exp_t;

    exp_t sb_rr[$];
    exp_t sb_fp[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mcnt;

    function automatic llc_req_pkt_t mk(input logic [27:0] a);
        llc_req_pkt_t p;
        p.coh_msg     = a[4:0];
        p.hprot       = a[1:0];
        p.addr        = a;
        p.line        = {4{4'h5, a}};
        p.req_id      = a[7:3];
        p.word_offset = a[1:0];
        p.valid_words = a[3:2];
        p.word_mask   = a[3:0];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rr_out();
        exp_t e;
        e = sb_rr.pop_front();
        chk("rr_out_valid", out_valid_rr, 1'b1);
        chk("rr_out_port", out_port_rr, e.port);
        chk("rr_out_data", out_data_rr, e.pkt);
    endtask

    task automatic check_fp_out();
        exp_t e;
        e = sb_fp.pop_front();
        chk("fp_out_valid", out_valid_fp, 1'b1);
        chk("fp_out_port", out_port_fp, e.port);
        chk("fp_out_data", out_data_fp, e.pkt);
    endtask

    initial begin
        // Reset held for three edges with every input valid.
        rst          = 1'b0;
        in_valid_rr  = 3'b111;
        in_valid_fp  = 3'b111;
        out_ready_rr = 1'b0;
        out_ready_fp = 1'b0;
        for (int p = 0; p < 3; p++) begin
            in_data_rr[p] = mk(28'h1 + 28'(p));
            in_data_fp[p] = mk(28'h1 + 28'(p));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_rr", in_ready_rr, 3'b000);
        chk("rst_in_ready_fp", in_ready_fp, 3'b000);
        chk("rst_out_valid_rr", out_valid_rr, 1'b0);
        chk("rst_stall_rr", stall_rr, 16'h0);
        chk("rst_occ_rr", occ_rr, 9'h0);
        rst         = 1'b1;
        in_valid_rr = 3'b000;
        in_valid_fp = 3'b000;
        step();
        chk("rel_in_ready_rr", in_ready_rr, 3'b111);
        chk("rel_in_ready_fp", in_ready_fp, 3'b111);
        chk("rel_occ_rr", occ_rr, 9'h0);
        chk("rel_out_valid_rr", out_valid_rr, 1'b0);
        chk("rel_out_port_rr", out_port_rr, 2'd0);

        // Five back-to-back pushes on port 0 with the output stalled.
        mcnt = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid_rr   = 3'b001;
            in_data_rr[0] = mk(28'h10 + 28'(k));
            chk("a_in_ready", in_ready_rr[0], (mcnt != 4));
            if (mcnt < 4) begin
                sb_rr.push_back('{port: 2'd0, pkt: mk(28'h10 + 28'(k))});
                mcnt++;
            end
            step();
        end
        in_valid_rr = 3'b000;
        chk("a_occ_full", occ_rr, {3'd0, 3'd0, 3'd4});
        chk("a_in_ready_full", in_ready_rr[0], 1'b0);
        out_ready_rr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_rr_out();
            step();
        end
        chk("a_drained_valid", out_valid_rr, 1'b0);
        chk("a_drained_occ", occ_rr, 9'h0);

        // Mid-transfer reset discards a queued entry.
        in_valid_rr   = 3'b010;
        in_data_rr[1] = mk(28'hEE);
        step();
        in_valid_rr = 3'b000;
        chk("r_occ_before", occ_rr, {3'd0, 3'd1, 3'd0});
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("r_occ_after", occ_rr, 9'h0);
        chk("r_valid_after", out_valid_rr, 1'b0);

        // Round-robin across three ports holding two entries each.
        out_ready_rr = 1'b0;
        for (int r = 0; r < 2; r++) begin
            in_valid_rr = 3'b111;
            for (int p = 0; p < 3; p++) begin
                in_data_rr[p] = mk(28'hA0 + 28'(p * 16) + 28'(r));
                sb_rr.push_back('{port: 2'(p), pkt: mk(28'hA0 + 28'(p * 16) + 28'(r))});
            end
            step();
        end
        in_valid_rr = 3'b000;
        chk("b_occ", occ_rr, {3'd2, 3'd2, 3'd2});
        out_ready_rr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_rr_out();
            step();
        end
        chk("b_drained_valid", out_valid_rr, 1'b0);

        // Fixed priority: a stalled port-2 grant must not yield to port 0.
        in_valid_fp   = 3'b100;
        in_data_fp[2] = mk(28'h2C0);
        sb_fp.push_back('{port: 2'd2, pkt: mk(28'h2C0)});
        step();
        in_valid_fp = 3'b000;
        chk("c_first_valid", out_valid_fp, 1'b1);
        chk("c_first_port", out_port_fp, 2'd2);
        in_valid_fp   = 3'b001;
        in_data_fp[0] = mk(28'h200);
        sb_fp.push_back('{port: 2'd0, pkt: mk(28'h200)});
        step();
        in_valid_fp = 3'b000;
        for (int k = 0; k < 3; k++) begin
            chk("c_lock_port", out_port_fp, 2'd2);
            chk("c_lock_data", out_data_fp, mk(28'h2C0));
            step();
        end
        chk("c_stall_cnt", stall_fp, 16'd4);
        out_ready_fp = 1'b1;
        check_fp_out();
        step();
        check_fp_out();
        step();
        chk("c_drained_valid", out_valid_fp, 1'b0);
        chk("c_stall_hold", stall_fp, 16'd4);

        // Full FIFO with a same-cycle pop: push blocked, ready returns next cycle.
        out_ready_fp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid_fp   = 3'b010;
            in_data_fp[1] = mk(28'h300 + 28'(k));
            sb_fp.push_back('{port: 2'd1, pkt: mk(28'h300 + 28'(k))});
            step();
        end
        in_valid_fp = 3'b000;
        chk("d_occ_full", occ_fp, {3'd0, 3'd4, 3'd0});
        chk("d_ready_full", in_ready_fp[1], 1'b0);
        out_ready_fp  = 1'b1;
        in_valid_fp   = 3'b010;
        in_data_fp[1] = mk(28'h3FF);
        chk("d_ready_blocked", in_ready_fp[1], 1'b0);
        check_fp_out();
        step();
        chk("d_occ_after_pop", occ_fp, {3'd0, 3'd3, 3'd0});
        chk("d_ready_rises", in_ready_fp[1], 1'b1);
        sb_fp.push_back('{port: 2'd1, pkt: mk(28'h3FF)});
        check_fp_out();
        step();
        in_valid_fp = 3'b000;
        chk("d_occ_push_pop", occ_fp, {3'd0, 3'd3, 3'd0});
        for (int k = 0; k < 3; k++) begin
            check_fp_out();
            step();
        end
        chk("d_drained_valid", out_valid_fp, 1'b0);
        chk("d_drained_occ", occ_fp, 9'h0);

        // Stall counter saturation.
        out_ready_fp  = 1'b0;
        in_valid_fp   = 3'b001;
        in_data_fp[0] = mk(28'h400);
        sb_fp.push_back('{port: 2'd0, pkt: mk(28'h400)});
        step();
        in_valid_fp = 3'b000;
        repeat (70000) @(posedge clk);
        #1;
        chk("e_stall_sat", stall_fp, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("e_stall_hold", stall_fp, 16'hFFFF);
        out_ready_fp = 1'b1;
        check_fp_out();
        step();
        chk("e_drained_valid", out_valid_fp, 1'b0);
        chk("e_stall_after", stall_fp, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
